// File: rtl/face_job_scheduler.sv
// rtl/face_job_scheduler.sv - dispatches face-detection tile jobs to a core bank and collects results round-robin
module face_job_scheduler #(
    parameter int NUM_CORES = 9,
    parameter int JOB_W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       go,
    input  logic [JOB_W-1:0]           num_jobs,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [NUM_CORES*JOB_W-1:0] core_job,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_hit,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [JOB_W-1:0]           result_job,
    output logic                       result_hit,
    output logic                       busy,
    output logic                       all_done,
    output logic [JOB_W-1:0]           faces,
    output logic                       err
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [NUM_CORES-1:0] run_q;
    logic [NUM_CORES-1:0] pend_q;
    logic [NUM_CORES-1:0] hit_q;
    logic [NUM_CORES-1:0] free_cores;
    logic [JOB_W-1:0]     num_jobs_q;
    logic [JOB_W-1:0]     next_job_q;
    logic [JOB_W-1:0]     disp_job;
    logic [JOB_W-1:0]     arb_job;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     disp_idx;
    logic [IDX_W-1:0]     arb_idx;
    logic                 disp_en;
    logic                 accept;
    logic                 arb_found;
    logic                 arb_hit;
    logic                 frame_go;
    logic                 zero_go;
    logic                 busy_nxt;
    logic                 all_done_nxt;

    assign free_cores = ~(run_q | pend_q);
    assign accept     = result_valid & result_ready;
    assign frame_go   = (state == S_IDLE) && go && (num_jobs != '0);
    assign zero_go    = (state == S_IDLE) && go && (num_jobs == '0);

    // The accepted go dispatches job 0 in the same edge so the first start lines up with busy.
    always_comb begin
        disp_idx = '0;
        disp_en  = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (free_cores[i]) begin
                disp_idx = IDX_W'(i);
                disp_en  = 1'b1;
            end
        end
        if (!(frame_go || ((state == S_DISPATCH) && (next_job_q < num_jobs_q)))) begin
            disp_en = 1'b0;
        end
        disp_job = frame_go ? '0 : next_job_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_go) begin
                    state_nxt = (num_jobs == JOB_W'(1)) ? S_DRAIN : S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if ((next_job_q == num_jobs_q) ||
                    (disp_en && ((next_job_q + JOB_W'(1)) == num_jobs_q))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (free_cores == '1) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_nxt     = (state_nxt != S_IDLE);
        all_done_nxt = (state_nxt == S_DONE) || zero_go;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            all_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= busy_nxt;
            all_done <= all_done_nxt;
        end
    end

    // Round-robin search: the lowest offset from rr_ptr among pending cores wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_job   = '0;
        arb_hit   = 1'b0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (pend_q[i] && (i == ((int'(rr_ptr) + k) % NUM_CORES))) begin
                    arb_found = 1'b1;
                    arb_idx   = IDX_W'(i);
                    arb_job   = core_job[i*JOB_W +: JOB_W];
                    arb_hit   = hit_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_start   <= '0;
            core_job     <= '0;
            run_q        <= '0;
            pend_q       <= '0;
            hit_q        <= '0;
            num_jobs_q   <= '0;
            next_job_q   <= '0;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            result_valid <= 1'b0;
            result_job   <= '0;
            result_hit   <= 1'b0;
            faces        <= '0;
            err          <= 1'b0;
        end else begin
            core_start <= '0;
            if (frame_go) begin
                num_jobs_q <= num_jobs;
                next_job_q <= '0;
            end
            if (go && (state != S_IDLE)) begin
                err <= 1'b1;
            end
            if (disp_en) begin
                next_job_q <= disp_job + JOB_W'(1);
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (disp_en && (disp_idx == IDX_W'(i))) begin
                    core_start[i]              <= 1'b1;
                    core_job[i*JOB_W +: JOB_W] <= disp_job;
                    run_q[i]                   <= 1'b1;
                end
                if (core_done[i]) begin
                    if (run_q[i]) begin
                        run_q[i]  <= 1'b0;
                        pend_q[i] <= 1'b1;
                        hit_q[i]  <= core_hit[i];
                    end else begin
                        err <= 1'b1;
                    end
                end
                if (accept && (grant_idx == IDX_W'(i))) begin
                    pend_q[i] <= 1'b0;
                end
            end
            // A presented result is frozen until accepted; the next grant follows one cycle later.
            if (accept) begin
                result_valid <= 1'b0;
                rr_ptr       <= (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + IDX_W'(1);
                if (result_hit && (faces != '1)) begin
                    faces <= faces + JOB_W'(1);
                end
            end else if (!result_valid && arb_found) begin
                result_valid <= 1'b1;
                grant_idx    <= arb_idx;
                result_job   <= arb_job;
                result_hit   <= arb_hit;
            end
            if (frame_go) begin
                faces <= '0;
            end
        end
    end
endmodule

// File: tb/tb_face_job_scheduler.sv
// tb/tb_face_job_scheduler.sv - directed self-checking bench for face_job_scheduler
`timescale 1ns/1ps
module tb_face_job_scheduler;
    localparam int NC = 9;
    localparam int JW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic [JW-1:0] num_jobs;
    logic [NC-1:0] core_start;
    logic [NC*JW-1:0] core_job;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_hit;
    logic          result_valid;
    logic          result_ready;
    logic [JW-1:0] result_job;
    logic          result_hit;
    logic          busy;
    logic          all_done;
    logic [JW-1:0] faces;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cnt [NC];
    bit busy_m [NC];
    int cur_job [NC];
    int start_cnt [NC];
    int job_core [256];
    int lat_tab [256];
    bit hit_tab [256];
    int acc_log [$];
    int done_cnt, done_edge, last_acc, overlap, starts, hit_bad;
    logic busy_at_done, busy_after_done;
    int exp3 [9] = '{3, 5, 7, 2, 0, 1, 4, 6, 8};
    int seen [32];
    int bad, unstable, s0;

    always #5 clk = ~clk;

    face_job_scheduler #(.NUM_CORES(NC), .JOB_W(JW)) dut (
        .clk(clk), .reset(reset), .go(go), .num_jobs(num_jobs),
        .core_start(core_start), .core_job(core_job),
        .core_done(core_done), .core_hit(core_hit),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_job(result_job), .result_hit(result_hit),
        .busy(busy), .all_done(all_done), .faces(faces), .err(err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge plus the behavioural core bank and result logger.
    task automatic tick();
        int j;
        if (result_valid === 1'b1 && result_ready === 1'b1) begin
            j = int'(result_job);
            acc_log.push_back(j);
            if (result_hit !== hit_tab[j]) hit_bad++;
            busy_m[job_core[j]] = 1'b0;
            last_acc = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        core_done = '0;
        core_hit  = '0;
        if (all_done === 1'b1) begin
            done_cnt++;
            done_edge    = cyc;
            busy_at_done = busy;
        end
        if (done_cnt > 0 && cyc == done_edge + 1) busy_after_done = busy;
        for (int i = 0; i < NC; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    core_done[i] = 1'b1;
                    core_hit[i]  = hit_tab[cur_job[i]];
                end
            end
            if (core_start[i] === 1'b1) begin
                if (busy_m[i]) overlap++;
                busy_m[i]  = 1'b1;
                cur_job[i] = int'(core_job[i*JW +: JW]);
                job_core[cur_job[i]] = i;
                cnt[i]     = lat_tab[cur_job[i]];
                starts++;
                start_cnt[i]++;
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NC; i++) begin
            cnt[i]    = 0;
            busy_m[i] = 1'b0;
        end
        core_done = '0;
        core_hit  = '0;
    endtask

    task automatic clear_stats();
        acc_log.delete();
        done_cnt = 0; done_edge = 0; last_acc = 0;
        overlap = 0; starts = 0; hit_bad = 0;
        busy_at_done = 1'bx; busy_after_done = 1'bx;
        for (int i = 0; i < NC; i++) start_cnt[i] = 0;
    endtask

    task automatic set_tables(input int lat);
        for (int j = 0; j < 256; j++) begin
            lat_tab[j] = lat;
            hit_tab[j] = 1'b0;
        end
    endtask

    task automatic start_frame(input int n);
        num_jobs = JW'(n);
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) tick();
        check_eq({tag, "_done_seen"}, 64'(done_cnt != 0), 1);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        go = 1'b0;
        result_ready = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_core_start"}, core_start, 0);
        check_eq({tag, "_core_job"}, core_job, 0);
        check_eq({tag, "_result_valid"}, result_valid, 0);
        check_eq({tag, "_result_job"}, result_job, 0);
        check_eq({tag, "_result_hit"}, result_hit, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_all_done"}, all_done, 0);
        check_eq({tag, "_faces"}, faces, 0);
        check_eq({tag, "_err"}, err, 0);
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; num_jobs = '0; result_ready = 1'b1;
        clear_model(); clear_stats(); set_tables(20);
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b0;

        // Nine jobs on nine cores, fixed latency 20, no hits.
        clear_stats();
        start_frame(9);
        check_eq("t1_busy", busy, 1);
        for (int i = 0; i < NC; i++) begin
            if (i > 0) tick();
            check_eq("t1_start", core_start, 64'(1) << i);
            check_eq("t1_job", core_job[i*JW +: JW], i);
        end
        wait_done("t1", 200);
        check_eq("t1_results", acc_log.size(), 9);
        bad = 0;
        foreach (acc_log[k]) if (acc_log[k] != k) bad++;
        check_eq("t1_order", bad, 0);
        check_eq("t1_all_done_cnt", done_cnt, 1);
        check_eq("t1_faces", faces, 0);
        check_eq("t1_drain_to_done_edges", done_edge - last_acc, 1);
        check_eq("t1_busy_at_done", busy_at_done, 1);
        check_eq("t1_busy_after_done", busy_after_done, 0);

        // Twenty jobs, mixed latencies, hits on jobs 3, 7 and 19.
        set_tables(0);
        for (int j = 0; j < 20; j++) lat_tab[j] = 5 + (j * 17) % 46;
        hit_tab[3] = 1'b1; hit_tab[7] = 1'b1; hit_tab[19] = 1'b1;
        clear_stats();
        start_frame(20);
        wait_done("t2", 600);
        for (int j = 0; j < 32; j++) seen[j] = 0;
        foreach (acc_log[k]) if (acc_log[k] < 32) seen[acc_log[k]]++;
        bad = 0;
        for (int j = 0; j < 20; j++) if (seen[j] != 1) bad++;
        check_eq("t2_each_once", bad, 0);
        check_eq("t2_results", acc_log.size(), 20);
        check_eq("t2_faces", faces, 3);
        check_eq("t2_overlap", overlap, 0);
        check_eq("t2_hit_flags", hit_bad, 0);
        check_eq("t2_all_done_cnt", done_cnt, 1);

        // Core 3 finishes alone (rr_ptr -> 4), then 2, 5, 7 finish together.
        set_tables(60);
        lat_tab[3] = 5; lat_tab[2] = 17; lat_tab[5] = 14; lat_tab[7] = 12;
        clear_stats();
        start_frame(9);
        wait_done("t3", 300);
        check_eq("t3_results", acc_log.size(), 9);
        for (int k = 0; k < 9; k++)
            check_eq("t3_order", (k < acc_log.size()) ? acc_log[k] : -1, exp3[k]);

        // Back-pressure: one result held for 30 cycles while job 9 waits for a core.
        set_tables(60);
        lat_tab[0] = 3; lat_tab[9] = 5; hit_tab[0] = 1'b1;
        clear_stats();
        result_ready = 1'b0;
        start_frame(10);
        for (int k = 0; k < 20 && result_valid !== 1'b1; k++) tick();
        check_eq("t4_valid", result_valid, 1);
        check_eq("t4_job", result_job, 0);
        check_eq("t4_hit", result_hit, 1);
        unstable = 0;
        s0 = start_cnt[0];
        repeat (30) begin
            tick();
            if (result_valid !== 1'b1 || result_job !== 8'd0 || result_hit !== 1'b1) unstable++;
        end
        check_eq("t4_stable", unstable, 0);
        check_eq("t4_no_restart_core0", start_cnt[0] - s0, 0);
        check_eq("t4_starts_held", starts, 9);
        result_ready = 1'b1;
        wait_done("t4", 300);
        check_eq("t4_job9_core", job_core[9], 0);
        check_eq("t4_results", acc_log.size(), 10);
        check_eq("t4_faces", faces, 1);
        check_eq("t4_err", err, 0);

        // Zero-job frame, then a done pulse from an idle core.
        clear_stats();
        num_jobs = '0;
        go = 1'b1;
        tick();
        go = 1'b0;
        check_eq("t5_zero_all_done", all_done, 1);
        check_eq("t5_zero_busy", busy, 0);
        tick();
        check_eq("t5_zero_all_done_off", all_done, 0);
        check_eq("t5_zero_busy_after", busy, 0);
        check_eq("t5_err_clear", err, 0);
        core_done = 9'b1 << 4;
        tick();
        check_eq("t5_done_free_err", err, 1);
        check_eq("t5_done_free_busy", busy, 0);
        do_reset();
        check_eq("t5_err_after_reset", err, 0);

        // go while busy is flagged and ignored.
        set_tables(10);
        clear_stats();
        start_frame(3);
        tick();
        tick();
        num_jobs = 8'd5;
        go = 1'b1;
        tick();
        go = 1'b0;
        check_eq("t5_go_busy_err", err, 1);
        wait_done("t5c", 100);
        check_eq("t5_go_busy_results", acc_log.size(), 3);
        check_eq("t5_go_busy_starts", starts, 3);
        check_eq("t5_go_busy_all_done", done_cnt, 1);

        // Reset at cycle 15 of a 20-job frame, then restart.
        do_reset();
        set_tables(0);
        for (int j = 0; j < 20; j++) lat_tab[j] = 5 + (j * 17) % 46;
        clear_stats();
        start_frame(20);
        repeat (14) tick();
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t6_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        clear_stats();
        repeat (3) tick();
        check_eq("t6_no_all_done", done_cnt, 0);
        check_eq("t6_idle_start", core_start, 0);
        set_tables(8);
        start_frame(2);
        check_eq("t6_restart_core0", core_start, 1);
        check_eq("t6_restart_job0", core_job[JW-1:0], 0);
        wait_done("t6", 100);
        check_eq("t6_results", acc_log.size(), 2);
        check_eq("t6_all_done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
